adc_axi_intf: RTL and testbench
===============================

ADC_AXI_INTF -- requirements
Module: adc_axi_intf

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 32, width of S_axis/M_axis data (only 32 supported).
REQ-002 SHALL have parameter ADC_WIDTH, default 16, width of each ADC I/Q sample.
REQ-003 SHALL have parameter PACKET_LEN, default 8, number of sample words per report packet (2..255).
REQ-004 SHALL have parameter FIFO_DEPTH, default 64, sample FIFO depth in words (power of 2, >= PACKET_LEN).
REQ-005 SHALL have parameter MAGIC_NUM, default 32'h45434D00, control/report magic word.
REQ-006 SHALL have port Clk, input, 1, sole clock for all logic.
REQ-007 SHALL have port Resetn, input, 1, reset; one clock; reset is synchronous and active-low.
REQ-008 SHALL have ports Adc_valid/Adc_data_i/Adc_data_q, input, 1/ADC_WIDTH/ADC_WIDTH, signed sample strobe and data.
REQ-009 SHALL have ports S_axis_valid/S_axis_data/S_axis_last, input, 1/32/1, and S_axis_ready, output, 1, control stream.
REQ-010 SHALL have ports M_axis_ready, input, 1, and M_axis_valid/M_axis_data/M_axis_last, output, 1/32/1, report stream.

Function
REQ-011 SHALL transfer a stream word only on a cycle with valid and ready both high; S_axis_ready SHALL be 1 whenever Resetn was high on the previous edge.
REQ-012 SHALL parse each control packet (words up to and including S_axis_last) as w0..w5; accept only if exactly 6 words and w0 == MAGIC_NUM, else discard whole packet with no effect.
REQ-013 Accepted packet SHALL apply at the cycle after the w5 beat: w4[0] -> capture enable register; w4[24] = 1 -> soft clear (empty FIFO, abort assembler, zero packet sequence and drop count) executed before the enable update; w1, w2, w3, w5 ignored.
REQ-014 While enabled, each Adc_valid cycle SHALL write word {Adc_data_q[15:0], Adc_data_i[15:0]} (sign-extended/truncated to 16 bits each) into the sample FIFO; while disabled samples are discarded.
REQ-015 FIFO full with Adc_valid and enable high SHALL drop the sample and increment a 16-bit saturating drop counter; simultaneous read and write on full SHALL accept the write.
REQ-016 Assembler states IDLE, HDR, SEQ, DATA: IDLE -> HDR when FIFO count >= PACKET_LEN; HDR emits MAGIC_NUM; SEQ emits {drop_count, packet_seq}; DATA emits PACKET_LEN FIFO words, M_axis_last on the final one, then -> IDLE and packet_seq increments (16-bit wrap at 0xFFFF -> 0).
REQ-017 M_axis_valid SHALL stay high and M_axis_data/M_axis_last stable until accepted; state advances only on accepted beats.
REQ-018 Latency: first header beat SHALL be valid no more than 3 cycles after the FIFO write that reaches PACKET_LEN entries.
REQ-019 Disabling capture mid-packet SHALL not abort the packet in progress; soft clear mid-packet SHALL drop M_axis_valid the next cycle and return to IDLE without a last beat.
REQ-020 M_axis_last SHALL be 0 whenever M_axis_valid is 0.

Reset
REQ-021 Resetn low at a Clk edge SHALL clear: S_axis_ready=0, M_axis_valid=0, M_axis_last=0, M_axis_data=0, enable=0, FIFO empty, state IDLE, parser at w0, packet_seq=0, drop_count=0.
REQ-022 Reset asserted mid-packet on either stream SHALL abandon that packet; the next S_axis beat after reset is treated as w0.

Configuration
REQ-023 Macro ADC_AXI_INTF_DROP_COUNT_EN defined: drop counter implemented and reported in SEQ word bits [31:16].
REQ-024 Macro undefined: no drop counter logic; SEQ word bits [31:16] SHALL be 0; dropping behaviour otherwise unchanged.

Verification
REQ-025 Send {MAGIC,0,0,DEADBEEF,01000000,DEADBEEF} then {MAGIC,1,0,DEADBEEF,00010101,DEADBEEF}; drive 8 samples i=n, q=-n -> one packet: MAGIC, 0x00000000, then {FFFF-n+1 style 16-bit -n, n} words, last on 10th beat.
REQ-026 Control packet with w0=0x12345678 or only 5 words -> enable unchanged, no report output for 100 samples.
REQ-027 Enabled, M_axis_ready=0 for 100 samples -> 64 stored, 36 dropped; release ready -> first packet SEQ word 0x00240000 (macro on) or 0x00000000 (macro off), 8 packets total after FIFO drains plus new data.
REQ-028 M_axis_ready random 80% high, 20 packets -> seq 0..19 in order, data equals input order, valid/data held stable under stall.
REQ-029 Soft clear packet sent during DATA state -> M_axis_valid low next cycle, following packet seq 0.
REQ-030 Resetn low 100 cycles mid-stream -> all outputs zero, S_axis_ready 0, enable 0 until reconfigured.

Source files
------------

// File: rtl/adc_axi_intf.sv
// ADC sample packetiser: I/Q samples are buffered in a FIFO and framed as report packets on M_axis.
// Magic-tagged control packets on S_axis drive it. ADC_AXI_INTF_DROP_COUNT_EN enables the drop counter.
// state | meaning
// IDLE  | waiting for PACKET_LEN words in the sample FIFO
// HDR   | presenting MAGIC_NUM header beat
// SEQ   | presenting {drop_count, packet_seq} beat
// DATA  | presenting FIFO words, M_axis_last on the final one
module adc_axi_intf #(
   parameter int          AXI_DATA_WIDTH = 32,
   parameter int          ADC_WIDTH      = 16,
   parameter int          PACKET_LEN     = 8,
   parameter int          FIFO_DEPTH     = 64,
   parameter logic [31:0] MAGIC_NUM      = 32'h45434D00
) (
   input  logic                      Clk,
   input  logic                      Resetn,
   input  logic                      Adc_valid,
   input  logic [ADC_WIDTH-1:0]      Adc_data_i,
   input  logic [ADC_WIDTH-1:0]      Adc_data_q,
   input  logic                      S_axis_valid,
   input  logic [AXI_DATA_WIDTH-1:0] S_axis_data,
   input  logic                      S_axis_last,
   output logic                      S_axis_ready,
   input  logic                      M_axis_ready,
   output logic                      M_axis_valid,
   output logic [AXI_DATA_WIDTH-1:0] M_axis_data,
   output logic                      M_axis_last
);

   localparam int            AW       = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   PL_C     = (AW+1)'(PACKET_LEN);
   localparam logic [7:0]    PL8      = 8'(PACKET_LEN);

   typedef enum logic [1:0] {IDLE, HDR, SEQ, DATA} state_t;

   state_t        state;
   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr, count;
   logic          full, fifo_wr, pop, m_acc;
   logic [15:0]   smp_i, smp_q, drop_cnt, pkt_seq;
   logic [7:0]    beat_cnt;
   logic [2:0]    ctl_cnt;
   logic          ctl_bad, cfg_en, cfg_clr, enable;
   logic          s_beat, ctl_accept, soft_clr;

   if (ADC_WIDTH >= 16) begin : g_trunc
      assign smp_i = Adc_data_i[15:0];
      assign smp_q = Adc_data_q[15:0];
   end else begin : g_sext
      assign smp_i = {{(16-ADC_WIDTH){Adc_data_i[ADC_WIDTH-1]}}, Adc_data_i};
      assign smp_q = {{(16-ADC_WIDTH){Adc_data_q[ADC_WIDTH-1]}}, Adc_data_q};
   end

   assign s_beat     = S_axis_valid && S_axis_ready;
   assign ctl_accept = s_beat && S_axis_last && (ctl_cnt == 3'd5) && !ctl_bad;
   assign soft_clr   = ctl_accept && cfg_clr;

   assign count   = wr_ptr - rd_ptr;
   assign full    = (count == DEPTH_C);
   assign m_acc   = M_axis_valid && M_axis_ready;
   // a FIFO word is popped when it is loaded into the output register, not when it leaves
   assign pop     = m_acc && ((state == SEQ) || ((state == DATA) && !M_axis_last));
   assign fifo_wr = Adc_valid && enable && (!full || pop) && !soft_clr;

   // control packet parser; ctl_cnt saturates at 6 so overlong packets are rejected
   always_ff @(posedge Clk) begin
      if (!Resetn) begin
         S_axis_ready <= 1'b0;
         ctl_cnt      <= 3'd0;
         ctl_bad      <= 1'b0;
         cfg_en       <= 1'b0;
         cfg_clr      <= 1'b0;
         enable       <= 1'b0;
      end else begin
         S_axis_ready <= 1'b1;
         if (s_beat) begin
            if (S_axis_last) begin
               ctl_cnt <= 3'd0;
               ctl_bad <= 1'b0;
            end else begin
               if (ctl_cnt != 3'd6)
                  ctl_cnt <= ctl_cnt + 3'd1;
               if ((ctl_cnt == 3'd0) && (S_axis_data != MAGIC_NUM))
                  ctl_bad <= 1'b1;
            end
            if (ctl_cnt == 3'd4) begin
               cfg_en  <= S_axis_data[0];
               cfg_clr <= S_axis_data[24];
            end
         end
         if (ctl_accept)
            enable <= cfg_en;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Resetn || soft_clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (fifo_wr)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge Clk) begin
      if (fifo_wr)
         mem[wr_ptr[AW-1:0]] <= {smp_q, smp_i};
   end

`ifdef ADC_AXI_INTF_DROP_COUNT_EN
   logic drop_evt;
   assign drop_evt = Adc_valid && enable && full && !pop;

   always_ff @(posedge Clk) begin
      if (!Resetn || soft_clr)
         drop_cnt <= 16'h0000;
      else if (drop_evt && (drop_cnt != 16'hFFFF))
         drop_cnt <= drop_cnt + 16'h0001;
   end
`else
   assign drop_cnt = 16'h0000;
`endif

   always_ff @(posedge Clk) begin
      if (!Resetn || soft_clr) begin
         state        <= IDLE;
         M_axis_valid <= 1'b0;
         M_axis_last  <= 1'b0;
         M_axis_data  <= '0;
         beat_cnt     <= 8'd0;
         pkt_seq      <= 16'h0000;
      end else begin
         case (state)
            IDLE: begin
               if (count >= PL_C) begin
                  M_axis_valid <= 1'b1;
                  M_axis_data  <= MAGIC_NUM;
                  M_axis_last  <= 1'b0;
                  state        <= HDR;
               end
            end
            HDR: begin
               if (m_acc) begin
                  M_axis_data <= {drop_cnt, pkt_seq};
                  state       <= SEQ;
               end
            end
            SEQ: begin
               if (m_acc) begin
                  M_axis_data <= mem[rd_ptr[AW-1:0]];
                  M_axis_last <= (PL8 == 8'd1);
                  beat_cnt    <= 8'd1;
                  state       <= DATA;
               end
            end
            DATA: begin
               if (m_acc) begin
                  if (M_axis_last) begin
                     M_axis_valid <= 1'b0;
                     M_axis_last  <= 1'b0;
                     pkt_seq      <= pkt_seq + 16'h0001;
                     state        <= IDLE;
                  end else begin
                     M_axis_data <= mem[rd_ptr[AW-1:0]];
                     M_axis_last <= ((beat_cnt + 8'd1) == PL8);
                     beat_cnt    <= beat_cnt + 8'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_axi_intf.sv
// Testbench for adc_axi_intf: directed control/sample sequences checked against a queue-based
// packet model every cycle, plus literal expectations for key beats.
module tb_adc_axi_intf;

   localparam logic [31:0] MAGIC = 32'h45434D00;
   localparam int          PL    = 8;
   localparam int          DEPTH = 64;

   logic        Clk = 1'b0;
   logic        Resetn = 1'b0;
   logic        Adc_valid = 1'b0;
   logic [15:0] Adc_data_i = '0;
   logic [15:0] Adc_data_q = '0;
   logic        S_axis_valid = 1'b0;
   logic [31:0] S_axis_data = '0;
   logic        S_axis_last = 1'b0;
   logic        S_axis_ready;
   logic        M_axis_ready = 1'b0;
   logic        M_axis_valid;
   logic [31:0] M_axis_data;
   logic        M_axis_last;

   always #5 Clk = ~Clk;

   adc_axi_intf dut (
      .Clk(Clk), .Resetn(Resetn),
      .Adc_valid(Adc_valid), .Adc_data_i(Adc_data_i), .Adc_data_q(Adc_data_q),
      .S_axis_valid(S_axis_valid), .S_axis_data(S_axis_data), .S_axis_last(S_axis_last),
      .S_axis_ready(S_axis_ready),
      .M_axis_ready(M_axis_ready), .M_axis_valid(M_axis_valid), .M_axis_data(M_axis_data),
      .M_axis_last(M_axis_last)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model state
   bit          m_en = 1'b0;
   logic [31:0] m_fifo[$];
   logic [31:0] ctrl_q[$];
   int          m_drop = 0, m_seq = 0, m_phase = 0, wait_cnt = 0;
   logic [32:0] beat_log[$];
   bit          prev_rst = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0, prev_clr = 1'b0;
   logic [31:0] prev_data = '0;

   int          rdy_mode = 0;
   bit          rdy_fixed = 1'b0;

   always @(negedge Clk) begin
      bit          clr_now;
      logic [15:0] dfield;
      logic [31:0] exp_w;
      clr_now = 1'b0;
      chk("s_ready", {31'd0, S_axis_ready}, {31'd0, prev_rst});
      if (!prev_rst) begin
         chk("rst_m_valid", {31'd0, M_axis_valid}, 0);
         chk("rst_m_last", {31'd0, M_axis_last}, 0);
         chk("rst_m_data", M_axis_data, 0);
      end else begin
         chk("last_without_valid", {31'd0, M_axis_last & ~M_axis_valid}, 0);
         if (prev_valid && !prev_ready && !prev_clr) begin
            chk("stall_valid", {31'd0, M_axis_valid}, 1);
            chk("stall_data", M_axis_data, prev_data);
            chk("stall_last", {31'd0, M_axis_last}, {31'd0, prev_last});
         end
         if (m_phase != 0)
            chk("pkt_valid", {31'd0, M_axis_valid}, 1);
         else if (m_fifo.size() < PL)
            chk("idle_valid", {31'd0, M_axis_valid}, 0);
         if (m_phase == 0 && m_fifo.size() >= PL && !M_axis_valid) begin
            wait_cnt++;
            chk("hdr_latency", {31'd0, wait_cnt <= 3}, 1);
         end else
            wait_cnt = 0;
      end

      if (!Resetn) begin
         m_en = 1'b0; m_fifo.delete(); ctrl_q.delete();
         m_drop = 0; m_seq = 0; m_phase = 0; wait_cnt = 0;
      end else begin
         if (M_axis_valid && M_axis_ready) begin
            beat_log.push_back({M_axis_last, M_axis_data});
            if (m_phase == 0) begin
               chk("hdr_word", M_axis_data, MAGIC);
               chk("hdr_last", {31'd0, M_axis_last}, 0);
            end else if (m_phase == 1) begin
`ifdef ADC_AXI_INTF_DROP_COUNT_EN
               dfield = m_drop[15:0];
`else
               dfield = 16'h0000;
`endif
               chk("seq_word", M_axis_data, {dfield, m_seq[15:0]});
               chk("seq_last", {31'd0, M_axis_last}, 0);
            end else begin
               if (m_fifo.size() == 0)
                  chk("data_available", 0, 1);
               else begin
                  exp_w = m_fifo.pop_front();
                  chk("data_word", M_axis_data, exp_w);
               end
               chk("data_last", {31'd0, M_axis_last}, {31'd0, m_phase == PL + 1});
            end
            m_phase++;
            if (m_phase == PL + 2) begin
               m_phase = 0;
               m_seq   = (m_seq + 1) & 16'hFFFF;
            end
         end
         if (Adc_valid && m_en) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back({Adc_data_q, Adc_data_i});
            else if (m_drop < 65535) m_drop++;
         end
         if (S_axis_valid && S_axis_ready) begin
            ctrl_q.push_back(S_axis_data);
            if (S_axis_last) begin
               if (ctrl_q.size() == 6 && ctrl_q[0] == MAGIC) begin
                  exp_w = ctrl_q[4];
                  if (exp_w[24]) begin
                     m_fifo.delete(); m_drop = 0; m_seq = 0; m_phase = 0; wait_cnt = 0;
                     clr_now = 1'b1;
                  end
                  m_en = exp_w[0];
               end
               ctrl_q.delete();
            end
         end
      end
      prev_rst   = Resetn;
      prev_valid = M_axis_valid;
      prev_ready = M_axis_ready;
      prev_data  = M_axis_data;
      prev_last  = M_axis_last;
      prev_clr   = clr_now;
   end

   initial begin
      forever begin
         @(posedge Clk);
         #2;
         M_axis_ready = (rdy_mode != 0) ? ($urandom_range(0, 99) < 80) : rdy_fixed;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic send_ctrl(input logic [31:0] w [8], input int n, input bit with_last);
      for (int i = 0; i < n; i++) begin
         int g;
         S_axis_valid = 1'b1;
         S_axis_data  = w[i];
         S_axis_last  = with_last && (i == n - 1);
         g = 0;
         while (!S_axis_ready && g < 50) begin tick(); g++; end
         if (g >= 50) chk("s_ready_timeout", 0, 1);
         tick();
      end
      S_axis_valid = 1'b0;
      S_axis_last  = 1'b0;
   endtask

   task automatic send_cfg(input logic [31:0] w4);
      send_ctrl('{MAGIC, 0, 0, 32'hDEADBEEF, w4, 32'hDEADBEEF, 0, 0}, 6, 1'b1);
   endtask

   task automatic sample(input logic [15:0] i, input logic [15:0] q, input int gap);
      Adc_valid  = 1'b1;
      Adc_data_i = i;
      Adc_data_q = q;
      tick();
      Adc_valid = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic wait_beats(input int n, input int budget);
      int c;
      c = 0;
      while (beat_log.size() < n && c < budget) begin tick(); c++; end
      chk("beat_count_reached", {31'd0, beat_log.size() >= n}, 1);
   endtask

   initial begin
      logic [32:0] b;
      int          lasts;
      // reset
      repeat (5) tick();
      chk("reset_m_valid", {31'd0, M_axis_valid}, 0);
      chk("reset_s_ready", {31'd0, S_axis_ready}, 0);
      Resetn = 1'b1;
      tick();

      // two config packets, eight samples i=n q=-n
      rdy_fixed = 1'b1;
      send_ctrl('{MAGIC, 0, 0, 32'hDEADBEEF, 32'h01000000, 32'hDEADBEEF, 0, 0}, 6, 1'b1);
      send_ctrl('{MAGIC, 1, 0, 32'hDEADBEEF, 32'h00010101, 32'hDEADBEEF, 0, 0}, 6, 1'b1);
      beat_log.delete();
      for (int n = 1; n <= 8; n++) sample(16'(n), 16'(-n), 0);
      wait_beats(10, 50);
      b = beat_log[0]; chk("t1_hdr", b[31:0], MAGIC);
      b = beat_log[1]; chk("t1_seq", b[31:0], 32'h00000000);
      b = beat_log[2]; chk("t1_first", {b[32], b[31:0]} == {1'b0, 32'hFFFF0001}, 1);
      b = beat_log[8]; chk("t1_beat9_last", {31'd0, b[32]}, 0);
      b = beat_log[9]; chk("t1_final", {b[32], b[31:0]} == {1'b1, 32'hFFF80008}, 1);

      // rejected control packets: wrong magic, too short, too long
      send_cfg(32'h00000000);
      send_ctrl('{32'h12345678, 0, 0, 0, 1, 0, 0, 0}, 6, 1'b1);
      send_ctrl('{MAGIC, 0, 0, 0, 1, 0, 0, 0}, 5, 1'b1);
      send_ctrl('{MAGIC, 0, 0, 0, 1, 0, 0, 0}, 7, 1'b1);
      beat_log.delete();
      for (int k = 0; k < 100; k++) sample(16'(k), 16'(k), 0);
      repeat (10) tick();
      chk("t2_no_output", beat_log.size(), 0);

      // overflow with stalled master: 64 stored, 36 dropped
      rdy_fixed = 1'b0;
      send_cfg(32'h01000001);
      beat_log.delete();
      for (int k = 0; k < 100; k++) sample(16'(k), 16'(k + 1000), 0);
      repeat (5) tick();
      rdy_fixed = 1'b1;
      wait_beats(80, 400);
      chk("t3_beats", beat_log.size(), 80);
      b = beat_log[1];
`ifdef ADC_AXI_INTF_DROP_COUNT_EN
      chk("t3_seq0", b[31:0], 32'h00240000);
`else
      chk("t3_seq0", b[31:0], 32'h00000000);
`endif
      b = beat_log[2];  chk("t3_first", b[31:0], 32'h03E80000);
      b = beat_log[79]; chk("t3_final", {b[32], b[31:0]} == {1'b1, 32'h0427003F}, 1);
      for (int k = 0; k < 8; k++) sample(16'(k), 16'(k), 0);
      wait_beats(90, 100);
      b = beat_log[81];
`ifdef ADC_AXI_INTF_DROP_COUNT_EN
      chk("t3_seq8", b[31:0], 32'h00240008);
`else
      chk("t3_seq8", b[31:0], 32'h00000008);
`endif

      // random back-pressure, 20 packets
      send_cfg(32'h01000001);
      rdy_mode = 1;
      beat_log.delete();
      for (int k = 0; k < 160; k++) sample(16'(k), 16'(k) ^ 16'hA5A5, 2);
      wait_beats(200, 2000);
      rdy_mode = 0;
      for (int p = 0; p < 20; p++) begin
         b = beat_log[p * 10 + 1];
         chk("t4_seq", b[31:0], 32'(p));
      end

      // soft clear while in DATA
      rdy_fixed = 1'b0;
      beat_log.delete();
      for (int k = 0; k < 8; k++) sample(16'(k + 50), 16'(k + 60), 0);
      repeat (4) tick();
      rdy_fixed = 1'b1;
      wait_beats(3, 20);
      rdy_fixed = 1'b0;
      repeat (3) tick();
      chk("t5_mid_packet", {31'd0, M_axis_valid}, 1);
      send_cfg(32'h01000001);
      chk("t5_valid_dropped", {31'd0, M_axis_valid}, 0);
      lasts = 0;
      foreach (beat_log[j]) begin b = beat_log[j]; if (b[32]) lasts++; end
      chk("t5_no_last", lasts, 0);
      beat_log.delete();
      rdy_fixed = 1'b1;
      for (int k = 0; k < 8; k++) sample(16'(k + 70), 16'(k + 80), 0);
      wait_beats(10, 50);
      b = beat_log[1]; chk("t5_seq_restart", b[31:0], 32'h00000000);
      b = beat_log[2]; chk("t5_data_after_clear", b[31:0], 32'h00500046);

      // long reset mid-stream, mid control packet
      rdy_fixed = 1'b0;
      for (int k = 0; k < 20; k++) sample(16'(k), 16'(k), 0);
      send_ctrl('{MAGIC, 0, 0, 0, 0, 0, 0, 0}, 3, 1'b0);
      Resetn = 1'b0;
      repeat (100) tick();
      chk("t6_rst_valid", {31'd0, M_axis_valid}, 0);
      chk("t6_rst_data", M_axis_data, 0);
      chk("t6_rst_last", {31'd0, M_axis_last}, 0);
      chk("t6_rst_s_ready", {31'd0, S_axis_ready}, 0);
      Resetn = 1'b1;
      rdy_fixed = 1'b1;
      tick();
      beat_log.delete();
      for (int k = 0; k < 20; k++) sample(16'(k), 16'(k), 0);
      repeat (5) tick();
      chk("t6_disabled_after_reset", beat_log.size(), 0);
      send_cfg(32'h00000001);
      for (int k = 0; k < 8; k++) sample(16'(k + 3), 16'hFFFE, 0);
      wait_beats(10, 50);
      b = beat_log[1]; chk("t6_seq0", b[31:0], 32'h00000000);
      b = beat_log[2]; chk("t6_first", b[31:0], 32'hFFFE0003);

      repeat (5) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
